piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in serial-out word serializer. It is the read-side counterpart to the team's 16-bit parallel-load register.
- It accepts a WIDTH-bit word through a load strobe and shifts the word out one bit per clock.
- Each bit carries framing (valid, first-bit and last-bit) plus a stall input.
- A one-word pending buffer lets a second word be accepted during shifting, so back-to-back words stream with no gap cycle.

Parameters:
- WIDTH, 16, word width in bits; must be 2 or more.
- LSB_FIRST, 1, bit order: 1 sends bit 0 first, 0 sends bit WIDTH-1 first.

Ports:
- clk  input  1  clock. All state updates on the falling edge, matching the datapath register timing.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  WIDTH  parallel word to serialize.
- ld  input  1  load request; the word is accepted on an edge where ld=1 and ready=1.
- hold  input  1  stall; freezes shifting while 1.
- ready  output  1  a word can be accepted this cycle.
- busy  output  1  a word is currently being shifted out.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit.
- sof  output  1  the current bit is the first bit of a word.
- eof  output  1  the current bit is the last bit of a word.

Behaviour:
- Reset: on an edge with rst=1, the block goes to IDLE and clears the bit counter, shift register and pending buffer. It drives sout=0, sout_valid=0, sof=0, eof=0, busy=0 and ready=1.
- rst dominates ld and hold. A reset mid-word aborts the word and discards any pending word; no partial-frame completion.
- Internal state: shift register, bit counter (0..WIDTH-1), pending buffer with a full flag, and a 2-state FSM (IDLE, SHIFT).
- ready = not pending-full. ready is 1 in IDLE.
- IDLE:
  - On accept, load the shift register directly and go to SHIFT.
  - Bit 0 of the frame appears on sout right after that edge, with sout_valid=1 and sof=1. Latency from accept to first bit is 0 cycles.
- SHIFT, on each edge with hold=0:
  - If counter < WIDTH-1: shift one position toward the output end, increment the counter, and present the next bit.
  - If counter = WIDTH-1 (last bit, eof=1) and the pending buffer is full: move pending into the shift register, clear pending-full, counter=0, sof=1 on the next bit.
  - If last bit, pending empty, and ld=1 (ready=1): load data_in straight into the shift register; pending stays empty; the next frame starts with sof=1.
  - If last bit, pending empty, and ld=0: go to IDLE and drive sout=0, sout_valid=0, busy=0.
- SHIFT, accept while not on the last-bit path above: the word goes into the pending buffer, and ready falls right after that edge.
- hold=1:
  - Counter, shift register and all serial outputs stay frozen; the current bit is repeated.
  - A word is still accepted into pending, or into the shift register from IDLE, in which case bit 0 is presented and held.
- ld while ready=0 is ignored, and the pending word is never overwritten.
- sof=1 only when counter=0. eof=1 only when counter=WIDTH-1. Both are gated by sout_valid.
- busy = (state==SHIFT).
- When sout_valid=0, sout=0.
- Frame length is WIDTH valid bit-cycles plus the number of hold cycles.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SHIFT).
  - Function returning counter width, clog2(WIDTH).
  - Bit-order constants (LSB_FIRST_ORDER=1, MSB_FIRST_ORDER=0).
- One sub-module, piso_word_buf: WIDTH-bit load-enabled holding register with full flag, set on load and cleared on take. Used for the pending buffer.

Test Plan:
- Single word, LSB_FIRST=1:
  - Stimulus: load 0xA5C3 from IDLE.
  - Required: sout = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 contiguous valid cycles.
  - Required: sof on cycle 0, eof on cycle 15, then sout_valid=0, busy=0 and ready=1 throughout.
- Back-to-back:
  - Stimulus: load 0x0001, then load 0x8000 at bit 3.
  - Required: ready=0 from bit 4 through the last bit of word 1.
  - Required: 32 contiguous valid cycles, sof at cycles 0 and 16, eof at cycles 15 and 31, and sout=1 only at cycles 0 and 31.
- Stall:
  - Stimulus: load 0xFFFF, assert hold for 3 cycles while bit 5 is presented.
  - Required: bit 5 visible for 4 cycles and eof at cycle 18 after accept.
  - Required: a ld of 0x1234 during the hold lands in pending and ready falls.
- Reset mid-operation:
  - Stimulus: rst at bit 7 with pending full.
  - Required: after that edge all outputs are 0 and ready=1.
  - Required: a subsequent load 0x00FF starts a fresh frame with sof=1 and emits 8 ones then 8 zeros. The pending word never appears.
- Direct chain on last bit:
  - Stimulus: ld 0x0003 coincides with the eof edge of a prior word, pending empty.
  - Required: no gap cycle; sof on the next cycle; sout=1,1 then 14 zeros; ready stays 1.
- MSB-first:
  - Stimulus: LSB_FIRST=0, load 0x8001.
  - Required: sout = 1, fourteen 0s, 1, with sof and eof on the first and last bits.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared FSM state, counter sizing and bit-order constants for the serializer
package piso_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;
  localparam bit LSB_FIRST_ORDER = 1'b1;
  localparam bit MSB_FIRST_ORDER = 1'b0;
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction
endpackage

// File: rtl/piso_word_buf.sv
// piso_word_buf: load-enabled word holding register with a full flag, set on load and cleared on take
module piso_word_buf #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             take_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             full_o
);
  logic [WIDTH-1:0] q_q;
  logic             full_q;
  always_ff @(negedge clk) begin
    if (rst) begin
      q_q    <= '0;
      full_q <= 1'b0;
    end else begin
      if (load_i) q_q <= d_i;
      full_q <= load_i ? 1'b1 : (take_i ? 1'b0 : full_q);
    end
  end
  assign q_o    = q_q;
  assign full_o = full_q;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out word serializer with framing, stall and a one-word pending buffer
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld,
  input  logic             hold,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             eof
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, pend;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             pend_full, pend_load, pend_take, accept, last;
  assign accept = ld & ready;
  assign last   = cnt_q == LAST;
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    pend_load = 1'b0;
    pend_take = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        state_d = SHIFT;
        sh_d    = data_in;
        cnt_d   = '0;
      end
    end else if (!hold && last) begin
      // End of frame: pending word first, then a direct load, else fall back to idle
      cnt_d = '0;
      if (pend_full) begin
        sh_d      = pend;
        pend_take = 1'b1;
      end else if (ld) begin
        sh_d = data_in;
      end else begin
        state_d = IDLE;
      end
    end else begin
      pend_load = accept;
      if (!hold) begin
        sh_d  = (LSB_FIRST == LSB_FIRST_ORDER) ? sh_q >> 1 : sh_q << 1;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end
  piso_word_buf #(.WIDTH(WIDTH)) u_pend (
    .clk    (clk),
    .rst    (rst),
    .load_i (pend_load),
    .take_i (pend_take),
    .d_i    (data_in),
    .q_o    (pend),
    .full_o (pend_full)
  );
  assign ready      = ~pend_full;
  assign sout_valid = state_q == SHIFT;
  assign busy       = sout_valid;
  assign sout       = sout_valid & ((LSB_FIRST == LSB_FIRST_ORDER) ? sh_q[0] : sh_q[WIDTH-1]);
  assign sof        = sout_valid & (cnt_q == '0);
  assign eof        = sout_valid & last;
endmodule
